board_lock_clear: RTL and testbench

//   Writer side of the game board. collision_* only read the board; this block owns the board register.
//   On lock_req it merges the landed 4x4 piece into the board (same cell mapping as the collision checks).
//   It then scans for full rows, deletes each one and shifts the rows above it down.

---
 rtl/board_lock_clear.sv | 197 +++++++++++++++++++
 tb/tb_board_lock_clear.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_lock_clear.sv
// Game-board writer: merges a landed 4x4 piece, then deletes full rows one row per cycle.
// Optional line scoring is enabled by defining LINE_SCORE_EN.
module board_lock_clear #(
    parameter int BLOCKS_W = 10,
    parameter int BLOCKS_H = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lock_req,
    input  logic                clear_board,
    input  logic [15:0]         piece_bool,
    input  logic [3:0]          piece_x,
    input  logic [4:0]          piece_y,
    input  logic [3:0]          piece_w,
    input  logic [3:0]          piece_h,
    output logic                busy,
    output logic                done,
    output logic [2:0]          lines_cleared,
    output logic                topped_out,
    output logic [15:0]         score,
    output logic [BLOCKS_W-1:0] game_board [BLOCKS_H]
);

    localparam int RW = $clog2(BLOCKS_H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_reg;
    logic [BLOCKS_W-1:0] board_reg [BLOCKS_H];
    logic [BLOCKS_W-1:0] piece_cells [BLOCKS_H];
    logic [BLOCKS_H-1:0] row_full;
    logic [15:0]         mask_reg;
    logic [3:0]          px_reg;
    logic [4:0]          py_reg;
    logic [3:0]          pw_reg;
    logic [3:0]          ph_reg;
    logic [RW-1:0]       row_reg;
    logic [2:0]          count_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [2:0]          lines_reg;
    logic                topped_reg;

    // Cells outside the piece bounding box (or the 4x4 mask) never hit; cells that
    // would land past the board edge simply have no board position to map onto.
    function automatic logic cell_hit(
        input int          row,
        input int          col,
        input logic [15:0] mask,
        input logic [3:0]  px,
        input logic [4:0]  py,
        input logic [3:0]  pw,
        input logic [3:0]  ph
    );
        int         dy;
        int         dx;
        logic [3:0] bit_idx;
        dy      = row - int'(py);
        dx      = col - int'(px);
        bit_idx = 4'(15 - 4 * dy - dx);
        return (dy >= 0) && (dy < 4) && (dy < int'(ph)) &&
               (dx >= 0) && (dx < 4) && (dx < int'(pw)) && mask[bit_idx];
    endfunction

    genvar gi, gj;
    generate
        for (gi = 0; gi < BLOCKS_H; gi++) begin : g_row
            assign row_full[gi]   = &board_reg[gi];
            assign game_board[gi] = board_reg[gi];
            for (gj = 0; gj < BLOCKS_W; gj++) begin : g_col
                assign piece_cells[gi][gj] = cell_hit(gi, gj, mask_reg, px_reg, py_reg,
                                                      pw_reg, ph_reg);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            for (int k = 0; k < BLOCKS_H; k++) begin
                board_reg[k] <= '0;
            end
            mask_reg   <= '0;
            px_reg     <= '0;
            py_reg     <= '0;
            pw_reg     <= '0;
            ph_reg     <= '0;
            row_reg    <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            lines_reg  <= '0;
            topped_reg <= 1'b0;
        end else if (clear_board) begin
            // New game: wipe the board and abandon any lock in flight without a done pulse.
            state_reg <= IDLE;
            for (int k = 0; k < BLOCKS_H; k++) begin
                board_reg[k] <= '0;
            end
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (lock_req) begin
                        mask_reg  <= piece_bool;
                        px_reg    <= piece_x;
                        py_reg    <= piece_y;
                        pw_reg    <= piece_w;
                        ph_reg    <= piece_h;
                        busy_reg  <= 1'b1;
                        state_reg <= MERGE;
                    end
                end
                MERGE: begin
                    for (int k = 0; k < BLOCKS_H; k++) begin
                        board_reg[k] <= board_reg[k] | piece_cells[k];
                    end
                    row_reg   <= RW'(BLOCKS_H - 1);
                    count_reg <= '0;
                    state_reg <= SCAN;
                end
                SCAN: begin
                    if (row_full[row_reg]) begin
                        // Drop everything above the full row by one; row_reg stays put so
                        // the row that slid into place gets checked next cycle.
                        for (int k = 1; k < BLOCKS_H; k++) begin
                            if (k <= int'(row_reg)) begin
                                board_reg[k] <= board_reg[k-1];
                            end
                        end
                        board_reg[0] <= '0;
                        if (count_reg != 3'd7) begin
                            count_reg <= count_reg + 3'd1;
                        end
                    end else if (row_reg == '0) begin
                        state_reg <= DONE;
                    end else begin
                        row_reg <= row_reg - RW'(1);
                    end
                end
                DONE: begin
                    done_reg   <= 1'b1;
                    lines_reg  <= count_reg;
                    topped_reg <= |board_reg[0];
                    busy_reg   <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef LINE_SCORE_EN
    logic [15:0] score_reg;
    logic [10:0] line_points;
    logic [16:0] score_sum;

    always_comb begin
        line_points = 11'd0;
        case (count_reg)
            3'd0:    line_points = 11'd0;
            3'd1:    line_points = 11'd40;
            3'd2:    line_points = 11'd100;
            3'd3:    line_points = 11'd300;
            default: line_points = 11'd1200;
        endcase
    end

    assign score_sum = {1'b0, score_reg} + 17'(line_points);

    // Score survives clear_board so a new game can still show the previous total.
    always_ff @(posedge clk) begin
        if (rst) begin
            score_reg <= '0;
        end else if (!clear_board && state_reg == DONE) begin
            score_reg <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end

    assign score = score_reg;
`else
    assign score = 16'd0;
`endif

    assign busy          = busy_reg;
    assign done          = done_reg;
    assign lines_cleared = lines_reg;
    assign topped_out    = topped_reg;

endmodule

// File: tb/tb_board_lock_clear.sv
// Scoreboard bench for board_lock_clear: a reference board model predicts each lock's outcome.
module tb_board_lock_clear;

    localparam int W = 10;
    localparam int H = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         lock_req;
    logic         clear_board;
    logic [15:0]  piece_bool;
    logic [3:0]   piece_x;
    logic [4:0]   piece_y;
    logic [3:0]   piece_w;
    logic [3:0]   piece_h;
    logic         busy;
    logic         done;
    logic [2:0]   lines_cleared;
    logic         topped_out;
    logic [15:0]  score;
    logic [W-1:0] game_board [H];

    board_lock_clear #(.BLOCKS_W(W), .BLOCKS_H(H)) dut (
        .clk(clk), .rst(rst), .lock_req(lock_req), .clear_board(clear_board),
        .piece_bool(piece_bool), .piece_x(piece_x), .piece_y(piece_y),
        .piece_w(piece_w), .piece_h(piece_h),
        .busy(busy), .done(done), .lines_cleared(lines_cleared),
        .topped_out(topped_out), .score(score), .game_board(game_board)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [H*W-1:0] board;
        logic [2:0]     lines;
        logic           topped;
        logic [15:0]    score;
        int             latency;
    } exp_t;

    exp_t         exp_q [$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] model_board [H];
    logic [15:0]  model_score;
    logic [2:0]   model_lines;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [H*W-1:0] flat_dut();
        logic [H*W-1:0] f;
        for (int r = 0; r < H; r++) f[r*W +: W] = game_board[r];
        return f;
    endfunction

    function automatic logic [H*W-1:0] flat_model();
        logic [H*W-1:0] f;
        for (int r = 0; r < H; r++) f[r*W +: W] = model_board[r];
        return f;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < H; r++) model_board[r] = '0;
    endtask

    // Reference: paint the piece, then rebuild the board from its non-full rows bottom-up.
    task automatic model_lock(input logic [3:0] px, input logic [4:0] py,
                              input logic [3:0] pw, input logic [3:0] ph,
                              input logic [15:0] mask);
        exp_t         e;
        logic [W-1:0] tmp [H];
        int           n;
        int           dst;
        int           pts;
        int           sum;
        for (int dy = 0; dy < 4; dy++)
            for (int dx = 0; dx < 4; dx++)
                if (dy < int'(ph) && dx < int'(pw) && mask[15 - 4*dy - dx] &&
                    int'(py) + dy < H && int'(px) + dx < W)
                    model_board[int'(py) + dy][int'(px) + dx] = 1'b1;
        for (int r = 0; r < H; r++) tmp[r] = '0;
        n   = 0;
        dst = H - 1;
        for (int r = H - 1; r >= 0; r--) begin
            if (&model_board[r]) n++;
            else begin
                tmp[dst] = model_board[r];
                dst--;
            end
        end
        for (int r = 0; r < H; r++) model_board[r] = tmp[r];
        model_lines = (n > 7) ? 3'd7 : 3'(n);
`ifdef LINE_SCORE_EN
        case (n)
            0: pts = 0;
            1: pts = 40;
            2: pts = 100;
            3: pts = 300;
            default: pts = 1200;
        endcase
        sum = int'(model_score) + pts;
        model_score = (sum > 65535) ? 16'hFFFF : 16'(sum);
`else
        pts = 0;
        sum = 0;
        model_score = 16'd0;
`endif
        e.board   = flat_model();
        e.lines   = model_lines;
        e.topped  = |model_board[0];
        e.score   = model_score;
        e.latency = 2 + H + n;
        exp_q.push_back(e);
    endtask

    task automatic do_clear();
        clear_board = 1'b1;
        step();
        clear_board = 1'b0;
        model_clear();
    endtask

    // One lock transaction; repulse_at >= 0 re-asserts lock_req at that cycle while busy.
    task automatic do_lock(input string name, input logic [3:0] px, input logic [4:0] py,
                           input logic [3:0] pw, input logic [3:0] ph,
                           input logic [15:0] mask, input int repulse_at);
        exp_t e;
        int   cyc;
        int   extra;
        piece_x = px; piece_y = py; piece_w = pw; piece_h = ph; piece_bool = mask;
        lock_req = 1'b1;
        model_lock(px, py, pw, ph, mask);
        step();
        lock_req = 1'b0;
        piece_x = 4'($urandom); piece_y = 5'($urandom); piece_bool = 16'($urandom);
        cyc = 0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_lock: got %b want 1", name, busy);
        end
        while (done !== 1'b1 && cyc < 200) begin
            lock_req = (cyc == repulse_at) ? 1'b1 : 1'b0;
            step();
            cyc++;
        end
        lock_req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: no done after %0d cycles, want %0d", name, cyc, e.latency);
            return;
        end
        $display("lock %-10s x=%0d y=%0d w=%0d h=%0d mask=%h lat=%0d lines=%0d top=%b score=%0d",
                 name, px, py, pw, ph, mask, cyc, lines_cleared, topped_out, score);
        if (cyc !== e.latency) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, e.latency);
        end
        checks++;
        if (lines_cleared !== e.lines) begin
            errors++;
            $display("FAIL %s lines_cleared: got %0d want %0d", name, lines_cleared, e.lines);
        end
        checks++;
        if (topped_out !== e.topped) begin
            errors++;
            $display("FAIL %s topped_out: got %b want %b", name, topped_out, e.topped);
        end
        checks++;
        if (score !== e.score) begin
            errors++;
            $display("FAIL %s score: got %0d want %0d", name, score, e.score);
        end
        checks++;
        if (flat_dut() !== e.board) begin
            errors++;
            $display("FAIL %s board: got %h want %h", name, flat_dut(), e.board);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy);
        end
        if (repulse_at >= 0) begin
            extra = 0;
            for (int i = 0; i < 40; i++) begin
                step();
                if (done === 1'b1) extra++;
            end
            checks++;
            if (extra !== 0) begin
                errors++;
                $display("FAIL %s extra_done: got %0d extra pulses want 0", name, extra);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        model_clear();
        model_score = '0;
        model_lines = '0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || topped_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b done=%b top=%b want 0 0 0", busy, done, topped_out);
        end
        checks++;
        if (score !== 16'd0 || lines_cleared !== 3'd0) begin
            errors++;
            $display("FAIL reset_counts: got score=%0d lines=%0d want 0 0", score, lines_cleared);
        end
        checks++;
        if (flat_dut() !== '0) begin
            errors++;
            $display("FAIL reset_board: got %h want 0", flat_dut());
        end
    endtask

    task automatic test_o_piece();
        do_lock("o_piece", 4'd0, 5'd18, 4'd2, 4'd2, 16'hCC00, -1);
        checks++;
        if (game_board[18] !== 10'h003 || game_board[19] !== 10'h003) begin
            errors++;
            $display("FAIL o_piece_rows: got %h %h want 003 003", game_board[18], game_board[19]);
        end
    endtask

    task automatic test_tetris();
        do_clear();
        do_lock("fill_a", 4'd0, 5'd16, 4'd4, 4'd4, 16'hFFFF, -1);
        do_lock("fill_b", 4'd4, 5'd16, 4'd4, 4'd4, 16'hFFFF, -1);
        do_lock("fill_c", 4'd8, 5'd16, 4'd1, 4'd4, 16'h8888, -1);
        do_lock("tetris", 4'd9, 5'd16, 4'd1, 4'd4, 16'h8888, -1);
        checks++;
        if (lines_cleared !== 3'd4 || flat_dut() !== '0) begin
            errors++;
            $display("FAIL tetris_result: got lines=%0d board=%h want 4 and empty", lines_cleared, flat_dut());
        end
    endtask

    task automatic test_shift();
        do_clear();
        do_lock("row19_a", 4'd1, 5'd19, 4'd4, 4'd1, 16'hF000, -1);
        do_lock("row19_b", 4'd5, 5'd19, 4'd4, 4'd1, 16'hF000, -1);
        do_lock("row19_c", 4'd9, 5'd19, 4'd1, 4'd1, 16'h8000, -1);
        do_lock("row18", 4'd9, 5'd18, 4'd1, 4'd1, 16'h8000, -1);
        do_lock("shift", 4'd0, 5'd16, 4'd1, 4'd4, 16'h8888, -1);
        checks++;
        if (game_board[19] !== 10'h201 || game_board[18] !== 10'h001 || game_board[16] !== 10'h000) begin
            errors++;
            $display("FAIL shift_rows: got r19=%h r18=%h r16=%h want 201 001 000",
                     game_board[19], game_board[18], game_board[16]);
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        do_lock("busy_req", 4'd3, 5'd10, 4'd3, 4'd2, 16'hE400, 3);
    endtask

    task automatic test_clear_mid_scan();
        int dones;
        piece_x = 4'd0; piece_y = 5'd18; piece_w = 4'd2; piece_h = 4'd2; piece_bool = 16'hCC00;
        lock_req = 1'b1;
        step();
        lock_req = 1'b0;
        repeat (5) step();
        clear_board = 1'b1;
        step();
        clear_board = 1'b0;
        model_clear();
        $display("clear mid-scan busy=%b lines=%0d score=%0d", busy, lines_cleared, score);
        checks++;
        if (flat_dut() !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_mid_scan: got board=%h busy=%b want 0 0", flat_dut(), busy);
        end
        checks++;
        if (lines_cleared !== model_lines || score !== model_score) begin
            errors++;
            $display("FAIL clear_keeps_stats: got lines=%0d score=%0d want %0d %0d",
                     lines_cleared, score, model_lines, model_score);
        end
        lock_req = 1'b1;
        clear_board = 1'b1;
        step();
        lock_req = 1'b0;
        clear_board = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_beats_lock: got busy=%b want 0", busy);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0 || flat_dut() !== '0) begin
            errors++;
            $display("FAIL clear_no_done: got %0d done pulses board=%h want 0 and empty", dones, flat_dut());
        end
    endtask

    task automatic test_clip();
        do_lock("clip_base", 4'd0, 5'd18, 4'd2, 4'd2, 16'hCC00, -1);
        do_lock("clip", 4'd8, 5'd10, 4'd4, 4'd1, 16'hF000, -1);
        checks++;
        if (game_board[10] !== 10'h300 || game_board[19] !== 10'h003) begin
            errors++;
            $display("FAIL clip_rows: got r10=%h r19=%h want 300 003", game_board[10], game_board[19]);
        end
    endtask

    task automatic test_reset_mid_op();
        piece_x = 4'd2; piece_y = 5'd5; piece_w = 4'd4; piece_h = 4'd4; piece_bool = 16'hFFFF;
        lock_req = 1'b1;
        step();
        lock_req = 1'b0;
        repeat (4) step();
        test_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            do_lock("random", 4'($urandom_range(0, 9)), 5'($urandom_range(0, 19)),
                    4'($urandom_range(1, 4)), 4'($urandom_range(1, 4)),
                    16'($urandom), -1);
        end
    endtask

    initial begin
        rst = 1'b1; lock_req = 1'b0; clear_board = 1'b0;
        piece_bool = '0; piece_x = '0; piece_y = '0; piece_w = 4'd1; piece_h = 4'd1;
        model_score = '0;
        model_lines = '0;
        test_reset();
        test_o_piece();
        test_tetris();
        test_shift();
        test_back_to_back();
        test_clear_mid_scan();
        test_clip();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
